// File: rtl/mips_pkg.sv
// Shared encodings for the MicroMIPS program-counter path.
package mips_pkg;

    localparam logic [1:0] PCSRC_SEQ     = 2'b00;
    localparam logic [1:0] PCSRC_JUMP    = 2'b01;
    localparam logic [1:0] PCSRC_JR      = 2'b10;
    localparam logic [1:0] PCSRC_SYSCALL = 2'b11;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLTZ = 3'b011;
    localparam logic [2:0] BR_BGEZ = 3'b100;
    localparam logic [2:0] BR_BLEZ = 3'b101;
    localparam logic [2:0] BR_BGTZ = 3'b110;
    localparam logic [2:0] BR_RSVD = 3'b111;

    localparam int unsigned INSTR_ALIGN = 2;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// push+pop together replaces the top entry.
module ras_stack #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full,
    output logic            ovf
);

    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PtrW-1:0] tp_q, tp_d, wr_idx;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            wr_en;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CntW'(RAS_DEPTH));
    assign top   = mem_q[tp_q];
    assign ovf   = ovf_q;

    always_comb begin
        tp_d   = tp_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        wr_en  = 1'b0;
        wr_idx = tp_q;
        if (push && pop && !empty) begin
            wr_en = 1'b1;
        end else if (push) begin
            // An empty push+pop falls through here and acts as a plain push.
            tp_d   = tp_q + PtrW'(1);
            wr_idx = tp_q + PtrW'(1);
            wr_en  = 1'b1;
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else if (pop && !empty) begin
            tp_d  = tp_q - PtrW'(1);
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            tp_q  <= tp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (wr_en) begin
                mem_q[wr_idx] <= wdata;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter register with next-PC selection, branch evaluation and a
// return-address stack that checks jr targets against predicted returns.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     RAS_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_VEC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic [1:0]      pc_src,
    input  logic [2:0]      br_type,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic [25:0]     jta,
    input  logic [XLEN-1:0] syscall_vec,
    input  logic            is_call,
    input  logic            is_ret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] incr_pc,
    output logic            br_taken,
    output logic            jr_misalign,
    output logic            ras_mispred,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_overflow
);

    localparam int unsigned SextW = XLEN - 16 - INSTR_ALIGN;

    logic [XLEN-1:0] pc_q, pc_d, next_pc, br_target, br_off, jr_target, ras_top;
    logic            mispred_q, mispred_d;
    logic            rs_neg, rs_zero, ret_valid, ras_push, ras_pop;
    logic            unused_syscall_lsbs;

    assign unused_syscall_lsbs = ^syscall_vec[INSTR_ALIGN-1:0];

    assign incr_pc     = pc_q + XLEN'(4);
    assign br_off      = {{SextW{jta[15]}}, jta[15:0], {INSTR_ALIGN{1'b0}}};
    assign br_target   = incr_pc + br_off;
    assign jr_target   = {rs_val[XLEN-1:INSTR_ALIGN], {INSTR_ALIGN{1'b0}}};
    assign jr_misalign = (pc_src == PCSRC_JR) && (rs_val[INSTR_ALIGN-1:0] != '0);
    assign rs_neg      = rs_val[XLEN-1];
    assign rs_zero     = (rs_val == '0);

    always_comb begin
        br_taken = 1'b0;
        if (pc_src == PCSRC_SEQ) begin
            case (br_type)
                BR_BEQ:  br_taken = (rs_val == rt_val);
                BR_BNE:  br_taken = (rs_val != rt_val);
                BR_BLTZ: br_taken = rs_neg;
                BR_BGEZ: br_taken = !rs_neg;
                BR_BLEZ: br_taken = rs_neg || rs_zero;
                BR_BGTZ: br_taken = !rs_neg && !rs_zero;
                default: br_taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (pc_src)
            PCSRC_SEQ:  next_pc = br_taken ? br_target : incr_pc;
            PCSRC_JUMP: next_pc = {incr_pc[XLEN-1:28], jta, 2'b00};
            PCSRC_JR:   next_pc = jr_target;
            default:    next_pc = {syscall_vec[XLEN-1:INSTR_ALIGN], {INSTR_ALIGN{1'b0}}};
        endcase
    end

    // A return only counts when it actually jumps through a register.
    assign ret_valid = is_ret && (pc_src == PCSRC_JR);
    assign ras_push  = is_call && !stall;
    assign ras_pop   = ret_valid && !stall;

    always_comb begin
        pc_d      = stall ? pc_q : next_pc;
        mispred_d = !stall && ret_valid && (ras_empty || (ras_top != jr_target));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_VEC;
            mispred_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            mispred_q <= mispred_d;
        end
    end

    assign pc          = pc_q;
    assign ras_mispred = mispred_q;

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .wdata (incr_pc),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full),
        .ovf   (ras_overflow)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer: next-PC table plus RAS/stall/reset sequences.
module tb_pc_sequencer;

    logic        clk, reset, stall;
    logic [1:0]  pc_src;
    logic [2:0]  br_type;
    logic [31:0] rs_val, rt_val, syscall_vec;
    logic [25:0] jta;
    logic        is_call, is_ret;
    logic [31:0] pc, incr_pc;
    logic        br_taken, jr_misalign, ras_mispred, ras_empty, ras_full, ras_overflow;

    int tests = 0;
    int fails = 0;

    pc_sequencer #(
        .XLEN      (32),
        .RAS_DEPTH (4),
        .RESET_VEC (32'h0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .pc_src       (pc_src),
        .br_type      (br_type),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .jta          (jta),
        .syscall_vec  (syscall_vec),
        .is_call      (is_call),
        .is_ret       (is_ret),
        .pc           (pc),
        .incr_pc      (incr_pc),
        .br_taken     (br_taken),
        .jr_misalign  (jr_misalign),
        .ras_mispred  (ras_mispred),
        .ras_empty    (ras_empty),
        .ras_full     (ras_full),
        .ras_overflow (ras_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] start;
        logic [1:0]  src;
        logic [2:0]  br;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [25:0] jt;
        logic [31:0] sv;
        logic        taken;
        logic        mis;
        logic [31:0] nxt;
    } vec_t;

    vec_t vecs[16];
    logic [31:0] ret_addrs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc_src      = 2'b00;
        br_type     = 3'b000;
        rs_val      = '0;
        rt_val      = '0;
        jta         = '0;
        syscall_vec = '0;
        is_call     = 1'b0;
        is_ret      = 1'b0;
    endtask

    task automatic set_pc(input logic [31:0] v);
        idle();
        pc_src = 2'b10;
        rs_val = v;
        tick();
        idle();
    endtask

    initial begin
        vecs[0]  = '{32'h100, 2'b00, 3'b001, 32'd5, 32'd5, 26'h000FFFF, 32'h0, 1'b1, 1'b0, 32'h100};
        vecs[1]  = '{32'h100, 2'b00, 3'b001, 32'd5, 32'd5, 26'h000FFFE, 32'h0, 1'b1, 1'b0, 32'h0FC};
        vecs[2]  = '{32'h100, 2'b00, 3'b001, 32'd5, 32'd6, 26'h000FFFE, 32'h0, 1'b0, 1'b0, 32'h104};
        vecs[3]  = '{32'h100, 2'b00, 3'b011, 32'h8000_0000, 32'h0, 26'h4, 32'h0, 1'b1, 1'b0, 32'h114};
        vecs[4]  = '{32'h100, 2'b00, 3'b011, 32'h1, 32'h0, 26'h4, 32'h0, 1'b0, 1'b0, 32'h104};
        vecs[5]  = '{32'h100, 2'b00, 3'b100, 32'h0, 32'h0, 26'h4, 32'h0, 1'b1, 1'b0, 32'h114};
        vecs[6]  = '{32'h100, 2'b00, 3'b110, 32'h0, 32'h0, 26'h4, 32'h0, 1'b0, 1'b0, 32'h104};
        vecs[7]  = '{32'h100, 2'b00, 3'b101, 32'h0, 32'h0, 26'h4, 32'h0, 1'b1, 1'b0, 32'h114};
        vecs[8]  = '{32'h100, 2'b00, 3'b010, 32'h1, 32'h2, 26'h1, 32'h0, 1'b1, 1'b0, 32'h108};
        vecs[9]  = '{32'h100, 2'b00, 3'b111, 32'h3, 32'h3, 26'h4, 32'h0, 1'b0, 1'b0, 32'h104};
        vecs[10] = '{32'h4000_0000, 2'b01, 3'b001, 32'h0, 32'h0, 26'h10, 32'h0, 1'b0, 1'b0,
                     32'h4000_0040};
        vecs[11] = '{32'h100, 2'b10, 3'b000, 32'h203, 32'h0, 26'h0, 32'h0, 1'b0, 1'b1, 32'h200};
        vecs[12] = '{32'h100, 2'b11, 3'b000, 32'h0, 32'h0, 26'h0, 32'h8000_0183, 1'b0, 1'b0,
                     32'h8000_0180};
        vecs[13] = '{32'hFFFF_FFFC, 2'b00, 3'b000, 32'h0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[14] = '{32'h100, 2'b00, 3'b110, 32'h7FFF_FFFF, 32'h0, 26'h000FFFF, 32'h0, 1'b1, 1'b0,
                     32'h100};
        vecs[15] = '{32'hF000_0100, 2'b01, 3'b000, 32'h0, 32'h0, 26'h3FF_FFFF, 32'h0, 1'b0, 1'b0,
                     32'hFFFF_FFFC};
        ret_addrs[0] = 32'h54;
        ret_addrs[1] = 32'h44;
        ret_addrs[2] = 32'h34;
        ret_addrs[3] = 32'h24;

        // Reset held with stall asserted, then released.
        idle();
        stall = 1'b1;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        stall = 1'b0;
        #1;
        chk("reset_pc", pc, 32'h0);
        chk("reset_incr", incr_pc, 32'h4);
        chk("reset_empty", {31'b0, ras_empty}, 32'h1);
        chk("reset_full", {31'b0, ras_full}, 32'h0);
        chk("reset_ovf", {31'b0, ras_overflow}, 32'h0);
        chk("reset_mispred", {31'b0, ras_mispred}, 32'h0);
        repeat (3) tick();
        chk("seq_3cycles", pc, 32'h0C);

        for (int i = 0; i < 16; i++) begin
            set_pc(vecs[i].start);
            pc_src      = vecs[i].src;
            br_type     = vecs[i].br;
            rs_val      = vecs[i].rs;
            rt_val      = vecs[i].rt;
            jta         = vecs[i].jt;
            syscall_vec = vecs[i].sv;
            #1;
            chk($sformatf("v%0d_br_taken", i), {31'b0, br_taken}, {31'b0, vecs[i].taken});
            chk($sformatf("v%0d_incr_pc", i), incr_pc, vecs[i].start + 32'd4);
            chk($sformatf("v%0d_jr_misalign", i), {31'b0, jr_misalign}, {31'b0, vecs[i].mis});
            tick();
            chk($sformatf("v%0d_next_pc", i), pc, vecs[i].nxt);
        end

        // Five calls into a four-deep stack: oldest return is lost.
        for (int k = 1; k <= 5; k++) begin
            set_pc(32'(k) * 32'h10);
            is_call = 1'b1;
            tick();
            is_call = 1'b0;
            if (k == 4) begin
                chk("ras_full_at4", {31'b0, ras_full}, 32'h1);
                chk("ras_ovf_at4", {31'b0, ras_overflow}, 32'h0);
            end
        end
        chk("ras_full_at5", {31'b0, ras_full}, 32'h1);
        chk("ras_ovf_at5", {31'b0, ras_overflow}, 32'h1);
        chk("ras_nonempty", {31'b0, ras_empty}, 32'h0);

        for (int r = 0; r < 4; r++) begin
            idle();
            pc_src = 2'b10;
            is_ret = 1'b1;
            rs_val = ret_addrs[r];
            tick();
            chk($sformatf("ret%0d_mispred", r), {31'b0, ras_mispred}, 32'h0);
            chk($sformatf("ret%0d_pc", r), pc, ret_addrs[r]);
        end
        idle();
        chk("ras_empty_after4", {31'b0, ras_empty}, 32'h1);
        pc_src = 2'b10;
        is_ret = 1'b1;
        rs_val = 32'h24;
        tick();
        chk("ret5_mispred", {31'b0, ras_mispred}, 32'h1);
        chk("ret5_empty", {31'b0, ras_empty}, 32'h1);
        idle();
        tick();
        chk("mispred_pulse", {31'b0, ras_mispred}, 32'h0);

        // Simultaneous call+ret replaces the top entry.
        set_pc(32'h60);
        is_call = 1'b1;
        tick();
        pc_src = 2'b10;
        is_ret = 1'b1;
        rs_val = 32'h64;
        tick();
        chk("callret_mispred", {31'b0, ras_mispred}, 32'h0);
        chk("callret_pc", pc, 32'h64);
        chk("callret_nonempty", {31'b0, ras_empty}, 32'h0);
        is_call = 1'b0;
        rs_val  = 32'h68;
        tick();
        chk("replaced_top", {31'b0, ras_mispred}, 32'h0);
        chk("replaced_empty", {31'b0, ras_empty}, 32'h1);

        // Stalled call and stalled empty pop must leave everything untouched.
        idle();
        stall   = 1'b1;
        is_call = 1'b1;
        tick();
        chk("stall_no_push", {31'b0, ras_empty}, 32'h1);
        chk("stall_pc_hold", pc, 32'h68);
        idle();
        pc_src = 2'b10;
        is_ret = 1'b1;
        tick();
        chk("stall_no_mispred", {31'b0, ras_mispred}, 32'h0);
        stall = 1'b0;

        // is_ret without jr is ignored.
        idle();
        is_ret = 1'b1;
        tick();
        chk("ret_nonjr_ignored", {31'b0, ras_mispred}, 32'h0);

        // Asynchronous reset in the middle of a cycle.
        idle();
        is_call = 1'b1;
        tick();
        idle();
        chk("pre_reset_nonempty", {31'b0, ras_empty}, 32'h0);
        chk("pre_reset_ovf", {31'b0, ras_overflow}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_empty", {31'b0, ras_empty}, 32'h1);
        chk("async_reset_ovf", {31'b0, ras_overflow}, 32'h0);
        chk("async_reset_pc", pc, 32'h0);
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
